xor_ann_checker: RTL

- Sequential response checker that sits directly downstream of the combinational xor_ann block.
- Samples A, B, H1, H2 and Y each time in_valid is high and compares them against the ideal XOR network (H1 = A|B, H2 = A&B or its NAND, Y = A^B).
- Counts passes and errors, tracks truth-table coverage, and latches the first failing vector.
- Raises done and pass once a programmed number of samples has been checked, replacing manual inspection of the $display table.

---
 rtl/xor_ann_checker.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/xor_ann_checker.sv
`default_nettype none
// ============================================================================
// Module   : xor_ann_checker
// Purpose  : Sequential response checker placed after the combinational
//            xor_ann network. Each accepted sample {A,B,H1,H2,Y} is compared
//            with the ideal XOR network (H1 = A|B, H2 = A&B or its NAND,
//            Y = A^B). The block counts passes and errors, tracks which input
//            combinations have been seen, latches the first failing vector and
//            reports done/pass after NUM_SAMPLES accepted samples.
// Ports    : clk, rst_n (async, active low)
//            start                 - pulse: clear statistics and arm a run
//            in_valid, A,B,H1,H2,Y - sample qualifier and sampled network nets
//            err_pulse             - one-cycle flag after a failing sample
//            pass_cnt, err_cnt     - saturating pass / fail counters
//            cov                   - cov[{A,B}] set once that combination is seen
//            first_err_vec/_vld    - {A,B,H1,H2,Y} of the first failure in a run
//            busy, done, pass      - run status
// Revision : 1.0 - initial release
// ============================================================================
module xor_ann_checker #(
  parameter int unsigned NUM_SAMPLES  = 4,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned H2_IS_NAND   = 0,
  parameter int unsigned CHECK_HIDDEN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic             A,
  input  logic             B,
  input  logic             H1,
  input  logic             H2,
  input  logic             Y,
  output logic             err_pulse,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [3:0]       cov,
  output logic [4:0]       first_err_vec,
  output logic             first_err_vld,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_max = '1;
  localparam logic [CNT_W-1:0] c_num     = CNT_W'(NUM_SAMPLES);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_sample_cnt;
  logic [CNT_W-1:0] w_sample_inc;
  logic             w_accept;
  logic             w_h2_exp;
  logic             w_hid_err;
  logic             w_err;

  // start has priority: a sample presented together with start is dropped.
  assign w_accept = (r_state == ST_RUN) & in_valid & ~start;

  assign w_h2_exp  = (H2_IS_NAND != 0) ? ~(A & B) : (A & B);
  assign w_hid_err = (H1 != (A | B)) | (H2 != w_h2_exp);
  assign w_err     = (Y != (A ^ B)) | ((CHECK_HIDDEN != 0) & w_hid_err);

  // Saturating increment; also used for the DONE decision so the state moves
  // on the same edge that accepts the final sample.
  assign w_sample_inc = (r_sample_cnt == c_cnt_max) ? r_sample_cnt
                                                    : r_sample_cnt + 1'b1;

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (start) begin
          w_state_nxt = ST_RUN;
        end else if (w_accept && (w_sample_inc == c_num)) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (r_state == ST_RUN);
  assign done = (r_state == ST_DONE);
  assign pass = done & (err_cnt == '0) & (cov == 4'hF);

  // --------------------------------------------------------------------------
  // Statistics
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse     <= 1'b0;
      pass_cnt      <= '0;
      err_cnt       <= '0;
      cov           <= 4'h0;
      first_err_vec <= 5'b0;
      first_err_vld <= 1'b0;
      r_sample_cnt  <= '0;
    end else if (start) begin
      err_pulse     <= 1'b0;
      pass_cnt      <= '0;
      err_cnt       <= '0;
      cov           <= 4'h0;
      first_err_vec <= 5'b0;
      first_err_vld <= 1'b0;
      r_sample_cnt  <= '0;
    end else if (w_accept) begin
      err_pulse    <= w_err;
      r_sample_cnt <= w_sample_inc;
      cov          <= cov | (4'b0001 << {A, B});
      if (w_err) begin
        if (err_cnt != c_cnt_max) err_cnt <= err_cnt + 1'b1;
        if (!first_err_vld) begin
          first_err_vec <= {A, B, H1, H2, Y};
          first_err_vld <= 1'b1;
        end
      end else begin
        if (pass_cnt != c_cnt_max) pass_cnt <= pass_cnt + 1'b1;
      end
    end else begin
      err_pulse <= 1'b0;
    end
  end

endmodule
`default_nettype wire
